// File: rtl/flash_read_arbiter_if.sv
// Purpose : bundle of request/response and quad-SPI pin signals for flash_read_arbiter.
// Latency : n/a (wires only).
// Backpres: reqN_ready is the only stall; responses and flash pins cannot be stalled.
// Ports   : slave  = arbiter side (drives ready/resp/rdata/flash pins, samples requests/flash_out)
//           master = environment side (requesters plus the flash device)
interface flash_read_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic [23:0] req0_addr;
    logic [23:0] req1_addr;
    logic        req0_ready;
    logic        req1_ready;
    logic        resp0_valid;
    logic        resp1_valid;
    logic [31:0] rdata;
    logic        flash_clk;
    logic        flash_csn;
    logic [3:0]  flash_in_en;
    logic [3:0]  flash_in;
    logic [3:0]  flash_out;

    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, flash_out,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, rdata,
               flash_clk, flash_csn, flash_in_en, flash_in
    );

    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, flash_out,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, rdata,
               flash_clk, flash_csn, flash_in_en, flash_in
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// Purpose : two-port round-robin arbiter driving one quad-SPI fast-read (cmd/addr/mode/dummy/data).
// Latency : accept edge E0 -> resp pulse in the cycle after E56; next accept earliest E(57+DESELECT_CYCLES).
// Backpres: reqN_ready high only in IDLE for the granted port; a pending request waits for the next IDLE.
// Ports   : clk, reset (async, active high), bus (flash_read_arbiter_if.slave): req0/1 valid/addr/ready,
//           resp0/1_valid, shared rdata, flash_clk/flash_csn/flash_in_en/flash_in out, flash_out in.
module flash_read_arbiter #(
    parameter logic [7:0] CMD             = 8'hEB,
    parameter int         DESELECT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    flash_read_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_DESEL
    } state_t;

    localparam logic [3:0] DESEL_LAST = 4'(DESELECT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    // r_phase: 0 = SCK low half (new data presented), 1 = SCK high half.
    // r_cnt  : SCK period index inside the current state; clk count inside DESEL.
    logic        r_phase;
    logic [3:0]  r_cnt;
    logic [23:0] r_addr;
    logic        r_port;
    logic        r_last;        // port granted most recently
    logic [31:0] r_buf;         // nibbles 0..6 assembled in place
    logic [31:0] r_rdata;
    logic        r_resp0;
    logic        r_resp1;

    logic        w_any_vld;
    logic        w_grant;       // 0 = port 0, 1 = port 1
    logic        w_accept;
    logic        w_last_period;
    logic        w_sample;
    logic        w_final_sample;
    logic [4:0]  w_nib_off;
    logic [23:0] w_addr_sh;
    logic [7:0]  w_cmd_sh;

    // ------------------------------------------------------------------
    // Arbitration: single requester wins outright, a tie goes to the port
    // that was not granted last.
    // ------------------------------------------------------------------
    assign w_any_vld = bus.req0_valid | bus.req1_valid;
    assign w_grant   = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
    assign w_accept  = (r_state == S_IDLE) & w_any_vld & ~reset;

    always_comb begin
        w_last_period = 1'b0;
        case (r_state)
            S_CMD:   w_last_period = (r_cnt == 4'd7);
            S_ADDR:  w_last_period = (r_cnt == 4'd5);
            S_MODE:  w_last_period = (r_cnt == 4'd1);
            S_DUMMY: w_last_period = (r_cnt == 4'd3);
            S_DATA:  w_last_period = (r_cnt == 4'd7);
            default: w_last_period = 1'b0;
        endcase
    end

    // flash_out is captured on the edge that closes each SCK high half.
    assign w_sample       = (r_state == S_DATA) & r_phase;
    assign w_final_sample = w_sample & w_last_period;

    // Nibble k lands at byte k/2; even k is the high nibble of that byte.
    assign w_nib_off = {r_cnt[2:1], ~r_cnt[0], 2'b00};

    // Shifted copies give the MSB-first bit/nibble for the current period.
    assign w_addr_sh = r_addr << {r_cnt[2:0], 2'b00};
    assign w_cmd_sh  = CMD << r_cnt[2:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Serial states advance on the edge closing the
    // high half of their last SCK period.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)                 w_next = S_CMD;
            S_CMD:   if (r_phase && w_last_period) w_next = S_ADDR;
            S_ADDR:  if (r_phase && w_last_period) w_next = S_MODE;
            S_MODE:  if (r_phase && w_last_period) w_next = S_DUMMY;
            S_DUMMY: if (r_phase && w_last_period) w_next = S_DATA;
            S_DATA:  if (r_phase && w_last_period) w_next = S_DESEL;
            S_DESEL: if (r_cnt == DESEL_LAST)      w_next = S_IDLE;
            default:                               w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Everything is decoded from registered state, so an
    // asynchronous reset raises flash_csn immediately.
    // ------------------------------------------------------------------
    always_comb begin
        bus.flash_csn   = 1'b1;
        bus.flash_clk   = 1'b0;
        bus.flash_in_en = 4'b0000;
        bus.flash_in    = 4'h0;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req0_ready = w_any_vld & ~w_grant & ~reset;
                bus.req1_ready = w_any_vld &  w_grant & ~reset;
            end
            S_CMD: begin
                bus.flash_csn   = 1'b0;
                bus.flash_clk   = r_phase;
                bus.flash_in_en = 4'b0001;
                bus.flash_in    = {3'b000, w_cmd_sh[7]};
            end
            S_ADDR: begin
                bus.flash_csn   = 1'b0;
                bus.flash_clk   = r_phase;
                bus.flash_in_en = 4'b1111;
                bus.flash_in    = w_addr_sh[23:20];
            end
            S_MODE: begin
                bus.flash_csn   = 1'b0;
                bus.flash_clk   = r_phase;
                bus.flash_in_en = 4'b1111;
            end
            S_DUMMY, S_DATA: begin
                bus.flash_csn   = 1'b0;
                bus.flash_clk   = r_phase;
            end
            default: begin
                // DESEL: pins parked by the defaults above
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase / period counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            if (r_state == S_IDLE || r_state == S_DESEL) begin
                r_phase <= 1'b0;
            end else begin
                r_phase <= ~r_phase;
            end

            if (w_next != r_state) begin
                r_cnt <= 4'd0;
            end else if (r_state == S_DESEL) begin
                r_cnt <= r_cnt + 4'd1;
            end else if (r_state != S_IDLE && r_phase) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch and round-robin pointer. Reset makes port 1 "last" so
    // port 0 wins the first tie.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= 24'h000000;
            r_port <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_addr <= w_grant ? bus.req1_addr : bus.req0_addr;
            r_port <= w_grant;
            r_last <= w_grant;
        end
    end

    // ------------------------------------------------------------------
    // Read data assembly. rdata only updates at the final sample, so it
    // holds the previous word for the whole of the next transfer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf   <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
            r_resp0 <= 1'b0;
            r_resp1 <= 1'b0;
        end else begin
            r_resp0 <= w_final_sample & ~r_port;
            r_resp1 <= w_final_sample &  r_port;
            if (w_final_sample) begin
                // nibble 7 is the low nibble of byte 3
                r_rdata <= {r_buf[31:28], bus.flash_out, r_buf[23:0]};
            end else if (w_sample) begin
                r_buf[w_nib_off +: 4] <= bus.flash_out;
            end
        end
    end

    assign bus.rdata       = r_rdata;
    assign bus.resp0_valid = r_resp0;
    assign bus.resp1_valid = r_resp1;

endmodule
